// File: rtl/timer_ctrl.sv
// timer_ctrl: control unit for the 8-bit timer.
// Owns the control, reload and status registers, edge-detects int_clk into
// single-cycle ticks and sequences the counter through IDLE, LOAD and RUN.
// Ports:
//   clk, preset_n          clock, async active-low reset
//   tcr_wr/tcr_wdata       control write {udie,ovie,load,en,dir,-,cks}
//   tdr_wr/tdr_wdata       reload value write
//   tsr_clr                write-1-to-clear {udf,ovf}
//   int_clk                selected divided clock, synchronous to clk
//   cks                    clock-select code to select_clock
//   tcr_q, tdr_q, tsr_q    register readback
//   tcnt                   current count
//   irq                    interrupt request
module timer_ctrl (
    input  logic       clk,
    input  logic       preset_n,
    input  logic       tcr_wr,
    input  logic [7:0] tcr_wdata,
    input  logic       tdr_wr,
    input  logic [7:0] tdr_wdata,
    input  logic [1:0] tsr_clr,
    input  logic       int_clk,
    output logic [1:0] cks,
    output logic [7:0] tcr_q,
    output logic [7:0] tdr_q,
    output logic [7:0] tcnt,
    output logic [1:0] tsr_q,
    output logic       irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic       udie_q, udie_d;
    logic       ovie_q, ovie_d;
    logic       en_q, en_d;
    logic       dir_q, dir_d;
    logic [1:0] cks_q, cks_d;
    logic [7:0] tdr_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic       ovf_q, ovf_d;
    logic       udf_q, udf_d;
    logic       int_clk_q;

    logic       tick;
    logic       load_wr;
    logic       ovf_set;
    logic       udf_set;
    logic       unused_wdata;

    // Bit 2 is reserved and intentionally ignored.
    assign unused_wdata = tcr_wdata[2];

    assign tick    = int_clk & ~int_clk_q;
    assign load_wr = tcr_wr & tcr_wdata[5];

    // Control and reload registers.
    always_comb begin
        udie_d = udie_q;
        ovie_d = ovie_q;
        en_d   = en_q;
        dir_d  = dir_q;
        cks_d  = cks_q;
        tdr_d  = tdr_q;
        if (tcr_wr) begin
            udie_d = tcr_wdata[7];
            ovie_d = tcr_wdata[6];
            en_d   = tcr_wdata[4];
            dir_d  = tcr_wdata[3];
            cks_d  = tcr_wdata[1:0];
        end
        if (tdr_wr) begin
            tdr_d = tdr_wdata;
        end
    end

    // Next state. A load write overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (load_wr) begin
            state_d = LOAD;
        end else begin
            unique case (state_q)
                IDLE: if (tcr_wr && tcr_wdata[4]) state_d = RUN;
                LOAD: state_d = en_q ? RUN : IDLE;
                RUN:  if (tcr_wr && !tcr_wdata[4]) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Counter and sticky flags. Ticks on a load edge are dropped.
    always_comb begin
        tcnt_d  = tcnt_q;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (state_q == LOAD) begin
            tcnt_d = tdr_q;
        end else if (state_q == RUN && tick && !load_wr) begin
            if (dir_q) begin
                tcnt_d  = tcnt_q - 8'd1;
                udf_set = (tcnt_q == 8'h00);
            end else begin
                tcnt_d  = tcnt_q + 8'd1;
                ovf_set = (tcnt_q == 8'hFF);
            end
        end
        // Set takes priority over a coincident clear.
        ovf_d = (ovf_q & ~tsr_clr[0]) | ovf_set;
        udf_d = (udf_q & ~tsr_clr[1]) | udf_set;
    end

    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            state_q   <= IDLE;
            udie_q    <= 1'b0;
            ovie_q    <= 1'b0;
            en_q      <= 1'b0;
            dir_q     <= 1'b0;
            cks_q     <= 2'b00;
            tdr_q     <= 8'h00;
            tcnt_q    <= 8'h00;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            int_clk_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            udie_q    <= udie_d;
            ovie_q    <= ovie_d;
            en_q      <= en_d;
            dir_q     <= dir_d;
            cks_q     <= cks_d;
            tdr_q     <= tdr_d;
            tcnt_q    <= tcnt_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            int_clk_q <= int_clk;
        end
    end

    assign cks   = cks_q;
    assign tcr_q = {udie_q, ovie_q, 1'b0, en_q, dir_q, 1'b0, cks_q};
    assign tcnt  = tcnt_q;
    assign tsr_q = {udf_q, ovf_q};
    assign irq   = (ovf_q & ovie_q) | (udf_q & udie_q);

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed self-checking bench for timer_ctrl.
// Inputs change and outputs are sampled 1ns after each rising clk edge.
module tb_timer_ctrl;

    logic       clk;
    logic       preset_n;
    logic       tcr_wr;
    logic [7:0] tcr_wdata;
    logic       tdr_wr;
    logic [7:0] tdr_wdata;
    logic [1:0] tsr_clr;
    logic       int_clk;
    logic [1:0] cks;
    logic [7:0] tcr_q;
    logic [7:0] tdr_q;
    logic [7:0] tcnt;
    logic [1:0] tsr_q;
    logic       irq;

    int checks = 0;
    int errors = 0;

    timer_ctrl dut (
        .clk       (clk),
        .preset_n  (preset_n),
        .tcr_wr    (tcr_wr),
        .tcr_wdata (tcr_wdata),
        .tdr_wr    (tdr_wr),
        .tdr_wdata (tdr_wdata),
        .tsr_clr   (tsr_clr),
        .int_clk   (int_clk),
        .cks       (cks),
        .tcr_q     (tcr_q),
        .tdr_q     (tdr_q),
        .tcnt      (tcnt),
        .tsr_q     (tsr_q),
        .irq       (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag,
                         input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr_tcr(input logic [7:0] v);
        tcr_wr    = 1'b1;
        tcr_wdata = v;
        step(1);
        tcr_wr    = 1'b0;
    endtask

    task automatic wr_tdr(input logic [7:0] v);
        tdr_wr    = 1'b1;
        tdr_wdata = v;
        step(1);
        tdr_wr    = 1'b0;
    endtask

    task automatic pulse(input int n);
        repeat (n) begin
            int_clk = 1'b1;
            step(1);
            int_clk = 1'b0;
            step(1);
        end
    endtask

    initial begin
        preset_n  = 1'b1;
        tcr_wr    = 1'b0;
        tcr_wdata = 8'h00;
        tdr_wr    = 1'b0;
        tdr_wdata = 8'h00;
        tsr_clr   = 2'b00;
        int_clk   = 1'b0;
        #2 preset_n = 1'b0;
        #1;
        check("rst_tcnt", tcnt, 8'h00);
        check("rst_tcr", tcr_q, 8'h00);
        check("rst_tdr", tdr_q, 8'h00);
        check("rst_tsr", {6'b0, tsr_q}, 8'h00);
        check("rst_irq", {7'b0, irq}, 8'h00);
        step(2);
        preset_n = 1'b1;
        step(1);

        // cks mirrors tcr[1:0]; en=0 keeps the FSM idle
        for (int c = 0; c < 4; c++) begin
            wr_tcr(8'(c));
            check("cks", {6'b0, cks}, 8'(c));
            check("cks_tcr", tcr_q, 8'(c));
        end

        // load and up count through overflow
        wr_tdr(8'hFC);
        check("tdr_q", tdr_q, 8'hFC);
        wr_tcr(8'h71);
        check("tcr_load_rd0", tcr_q, 8'h51);
        step(1);
        check("up_load", tcnt, 8'hFC);
        pulse(3);
        check("up_3", tcnt, 8'hFF);
        check("up_3_ovf", {6'b0, tsr_q}, 8'h00);
        pulse(1);
        check("up_wrap", tcnt, 8'h00);
        check("up_ovf", {6'b0, tsr_q}, 8'h01);
        check("up_irq", {7'b0, irq}, 8'h01);
        tsr_clr = 2'b01;
        step(1);
        tsr_clr = 2'b00;
        check("ovf_clr", {6'b0, tsr_q}, 8'h00);
        check("ovf_clr_irq", {7'b0, irq}, 8'h00);

        // down count through underflow
        wr_tdr(8'h02);
        wr_tcr(8'hB8);
        step(1);
        check("dn_load", tcnt, 8'h02);
        pulse(1);
        check("dn_1", tcnt, 8'h01);
        pulse(1);
        check("dn_2", tcnt, 8'h00);
        check("dn_2_udf", {6'b0, tsr_q}, 8'h00);
        pulse(1);
        check("dn_wrap", tcnt, 8'hFF);
        check("dn_udf", {6'b0, tsr_q}, 8'h02);
        check("dn_irq", {7'b0, irq}, 8'h01);
        tsr_clr = 2'b10;
        step(1);
        tsr_clr = 2'b00;
        check("udf_clr", {6'b0, tsr_q}, 8'h00);
        check("udf_clr_irq", {7'b0, irq}, 8'h00);

        // stop and resume
        wr_tdr(8'h0F);
        wr_tcr(8'h30);
        step(1);
        pulse(1);
        check("sr_run", tcnt, 8'h10);
        wr_tcr(8'h00);
        pulse(5);
        check("sr_hold", tcnt, 8'h10);
        wr_tcr(8'h10);
        pulse(1);
        check("sr_resume", tcnt, 8'h11);

        // tick on the tcr_wr load edge is dropped
        wr_tdr(8'h40);
        int_clk   = 1'b1;
        tcr_wr    = 1'b1;
        tcr_wdata = 8'h30;
        step(1);
        tcr_wr    = 1'b0;
        step(1);
        check("drop_wr", tcnt, 8'h40);
        int_clk = 1'b0;
        step(1);
        check("drop_wr_hold", tcnt, 8'h40);

        // tick on the LOAD-state edge is dropped
        wr_tdr(8'h50);
        wr_tcr(8'h30);
        int_clk = 1'b1;
        step(1);
        int_clk = 1'b0;
        check("drop_ld", tcnt, 8'h50);
        step(1);
        check("drop_ld_hold", tcnt, 8'h50);

        // clear coincident with overflow: set wins
        wr_tdr(8'hFF);
        wr_tcr(8'h70);
        step(1);
        int_clk = 1'b1;
        tsr_clr = 2'b01;
        step(1);
        int_clk = 1'b0;
        tsr_clr = 2'b00;
        check("setclr_cnt", tcnt, 8'h00);
        check("setclr_ovf", {6'b0, tsr_q}, 8'h01);
        check("setclr_irq", {7'b0, irq}, 8'h01);
        tsr_clr = 2'b01;
        step(1);
        tsr_clr = 2'b00;

        // int_clk held high counts once
        int_clk = 1'b1;
        step(10);
        int_clk = 1'b0;
        step(1);
        check("edge_once", tcnt, 8'h01);

        // async reset mid-count
        wr_tdr(8'h36);
        wr_tcr(8'h71);
        step(1);
        pulse(1);
        check("pre_rst", tcnt, 8'h37);
        #2 preset_n = 1'b0;
        #1;
        check("mid_rst_tcnt", tcnt, 8'h00);
        check("mid_rst_tcr", tcr_q, 8'h00);
        check("mid_rst_cks", {6'b0, cks}, 8'h00);
        check("mid_rst_tsr", {6'b0, tsr_q}, 8'h00);
        check("mid_rst_irq", {7'b0, irq}, 8'h00);
        step(2);
        preset_n = 1'b1;
        step(1);
        pulse(3);
        check("post_rst", tcnt, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Control unit for the 8-bit timer. It owns the timer control, data and status registers and drives the clock-select code to `select_clock`. It turns the selected `int_clk` into single-cycle count ticks and sequences the 8-bit counter through idle, load and run, raising overflow and underflow flags and an interrupt request.

## Interface
- No parameters; widths are fixed at 8 bits.
- clk  input  1  system clock; all state updates on the rising edge.
- preset_n  input  1  asynchronous active-low reset.
- tcr_wr  input  1  write strobe for the control register.
- tcr_wdata  input  8  control data: [7] udie, [6] ovie, [5] load (self-clearing), [4] en, [3] dir (0 = up, 1 = down), [2] reserved, [1:0] cks.
- tdr_wr  input  1  write strobe for the reload register.
- tdr_wdata  input  8  reload value.
- tsr_clr  input  2  write-1-to-clear: [0] ovf, [1] udf.
- int_clk  input  1  selected divided clock from `select_clock`, synchronous to clk.
- cks  output  2  clock-select code to `select_clock`; equals tcr[1:0].
- tcr_q  output  8  control register readback; bits [5] and [2] always read 0.
- tdr_q  output  8  reload register readback.
- tcnt  output  8  current count.
- tsr_q  output  2  status: [0] ovf, [1] udf.
- irq  output  1  interrupt request: (ovf & ovie) | (udf & udie).

## Operation
- Reset (preset_n = 0, asynchronous): tcr = 0x00, tdr = 0x00, tcnt = 0x00, ovf = udf = 0, int_clk_d = 0, state IDLE. All outputs are therefore 0.
- Tick detect: int_clk_d <= int_clk on every cycle, in every state. tick = int_clk & ~int_clk_d, one clk cycle wide per rising edge of int_clk.
- tcr_wr loads bits 7:6, 4:3 and 1:0. The load bit is not stored; it only drives the FSM. tdr_wr loads tdr.
- FSM states:
  - IDLE: counter is held.
  - LOAD: tcnt <= tdr for exactly one cycle; ticks are ignored.
  - RUN: on tick, tcnt increments (dir = 0) or decrements (dir = 1).
- FSM transitions:
  - Any state -> LOAD on tcr_wr with tcr_wdata[5] = 1.
  - LOAD -> RUN if en = 1, otherwise LOAD -> IDLE.
  - IDLE -> RUN on tcr_wr with en = 1 and load = 0.
  - RUN -> IDLE on tcr_wr with en = 0 and load = 0. The counter keeps its value.
- Arithmetic is modulo 256.
  - Up: 0xFF + tick -> 0x00 and sets ovf.
  - Down: 0x00 + tick -> 0xFF and sets udf.
  - The counter does not auto-reload; software issues a load.
- Flags are sticky until cleared via tsr_clr. If set and clear happen in the same cycle, set wins.
- dir or cks changes during RUN take effect from the next tick. A change of cks may create or swallow one tick edge; this is accepted.
- tdr_wr during RUN does not disturb tcnt; the new value is used on the next LOAD.

## Timing
- tcr_wr with load at edge N: tcr_q updated after N, state LOAD after N, tcnt = tdr after N+1, state RUN or IDLE after N+1.
- If tdr_wr and tcr_wr(load) occur at the same edge N, the new tdr value is loaded at N+1.
- int_clk rises before edge M: tick is seen at edge M, and tcnt plus the flags update after edge M. The latency is 1 clk from the int_clk rise.
- irq is combinational from registered flags and tcr, so it is valid in the same cycle the flag is set.
- A tick coincident with a load edge (state LOAD or a tcr_wr load) is dropped, and no flag is set.
- Reset asserted mid-run returns everything to reset values immediately. After release, counting needs a fresh tcr_wr.

## Test plan
- Reset check: assert preset_n = 0 mid-count at tcnt = 0x37 -> tcnt, tsr_q, irq, cks and tcr_q all read 0 immediately; no ticks are counted after release.
- Load and up count: write tdr = 0xFC, then tcr = 0x71 (ovie, load, en, cks = 01) -> tcnt = 0xFC one cycle after the LOAD state. After 4 int_clk rises, tcnt = 0x00 with ovf = 1 and irq = 1.
- Down count and underflow: tdr = 0x02, tcr = 0xB8 (udie, load, en, dir) -> sequence 0x02, 0x01, 0x00, 0xFF, with udf = 1 and irq = 1 at the 3rd tick. tsr_clr = 2'b10 -> udf = 0 and irq = 0.
- Stop and resume: in RUN at tcnt = 0x10, write tcr with en = 0 -> tcnt holds at 0x10 over 5 ticks. Write en = 1 -> the next tick gives 0x11.
- Simultaneous events: a tick coincident with the load edge is dropped (tcnt = tdr exactly). A tsr_clr[0] coincident with an overflow tick leaves ovf = 1.
- Edge detect: hold int_clk high for 10 clk -> exactly one increment. Check cks output equals tcr[1:0] for all four codes.
